// File: rtl/ahb_arbiter.sv
// ahb_arbiter: three-master AHB-lite bus arbiter.
// Round-robin ownership with a per-tenure beat limit, locked-sequence
// hold, and a registered address-to-data master pipeline.
module ahb_arbiter #(
  parameter int MAX_BEATS      = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic       hbusreq_0,
  input  logic       hbusreq_1,
  input  logic       hbusreq_2,
  input  logic       hlock_0,
  input  logic       hlock_1,
  input  logic       hlock_2,
  input  logic [1:0] htrans,
  input  logic       hready,
  output logic       hgrant_0,
  output logic       hgrant_1,
  output logic       hgrant_2,
  output logic [1:0] hmaster,
  output logic [1:0] hmaster_data,
  output logic       hmastlock
);

  localparam logic [1:0] DEF  = DEFAULT_MASTER[1:0];
  localparam logic [7:0] MAXB = MAX_BEATS[7:0];

  typedef enum logic [1:0] {S_PARK, S_OWN, S_LOCK} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [7:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic       r_mastlock, w_mastlock_nxt;
  logic [1:0] r_mdata;

  logic [2:0] w_req, w_lock;
  logic [1:0] w_n1, w_n2, w_other;
  logic       w_other_vld, w_any, w_own_req, w_own_lock;

  assign w_req  = {hbusreq_2, hbusreq_1, hbusreq_0};
  assign w_lock = {hlock_2, hlock_1, hlock_0};

  // Round-robin search order relative to the current owner
  assign w_n1 = (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
  assign w_n2 = (w_n1 == 2'd2) ? 2'd0 : w_n1 + 2'd1;

  assign w_other_vld = w_req[w_n1] | w_req[w_n2];
  assign w_other     = w_req[w_n1] ? w_n1 : w_n2;
  assign w_any       = |w_req;
  assign w_own_req   = w_req[r_owner];
  // A lock only counts when the owner is also requesting
  assign w_own_lock  = w_own_req & w_lock[r_owner];

  // Only NONSEQ/SEQ beats count; saturate at the limit
  assign w_cnt_inc = (r_cnt == MAXB) ? r_cnt : r_cnt + {7'd0, htrans[1]};

  // Next-state / ownership decision, applied only on hready edges
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_cnt_nxt      = r_cnt;
    w_mastlock_nxt = r_mastlock;
    case (r_state)
      S_PARK: begin
        if (w_any) begin
          w_state_nxt = S_OWN;
          w_owner_nxt = w_other_vld ? w_other : r_owner;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_OWN: begin
        if (w_own_lock) begin
          w_state_nxt    = S_LOCK;
          w_mastlock_nxt = 1'b1;
          w_cnt_nxt      = w_cnt_inc;
        end else if (!w_own_req && w_other_vld) begin
          w_owner_nxt = w_other;
          w_cnt_nxt   = 8'd0;
        end else if (!w_any) begin
          w_state_nxt = S_PARK;
          w_owner_nxt = DEF;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == MAXB && w_other_vld) begin
          w_owner_nxt = w_other;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_LOCK: begin
        // Lock exit clears the counter, so the beat limit cannot fire here
        if (!w_own_lock) begin
          w_mastlock_nxt = 1'b0;
          w_cnt_nxt      = 8'd0;
          w_state_nxt    = S_OWN;
          if (!w_own_req && w_other_vld) begin
            w_owner_nxt = w_other;
          end else if (!w_any) begin
            w_state_nxt = S_PARK;
            w_owner_nxt = DEF;
          end
        end
      end
      default: begin
        w_state_nxt    = S_PARK;
        w_owner_nxt    = DEF;
        w_cnt_nxt      = 8'd0;
        w_mastlock_nxt = 1'b0;
      end
    endcase
  end

  // State registers; everything freezes while hready is low
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state    <= S_PARK;
      r_owner    <= DEF;
      r_cnt      <= 8'd0;
      r_mastlock <= 1'b0;
      r_mdata    <= DEF;
    end else if (hready) begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mastlock <= w_mastlock_nxt;
      r_mdata    <= r_owner;
    end
  end

  assign hgrant_0     = (r_owner == 2'd0);
  assign hgrant_1     = (r_owner == 2'd1);
  assign hgrant_2     = (r_owner == 2'd2);
  assign hmaster      = r_owner;
  assign hmaster_data = r_mdata;
  assign hmastlock    = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: a behavioural model predicts the
// registered outputs after each edge; predictions are queued at drive
// time and popped/compared one time unit after the edge.
module tb_ahb_arbiter;

  localparam int MAXB = 4;
  localparam int DEF  = 0;

  logic       hclk, hreset;
  logic       hbusreq_0, hbusreq_1, hbusreq_2;
  logic       hlock_0, hlock_1, hlock_2;
  logic [1:0] htrans;
  logic       hready;
  logic       hgrant_0, hgrant_1, hgrant_2;
  logic [1:0] hmaster, hmaster_data;
  logic       hmastlock;

  ahb_arbiter #(.MAX_BEATS(MAXB), .DEFAULT_MASTER(DEF)) dut (
    .hclk(hclk), .hreset(hreset),
    .hbusreq_0(hbusreq_0), .hbusreq_1(hbusreq_1), .hbusreq_2(hbusreq_2),
    .hlock_0(hlock_0), .hlock_1(hlock_1), .hlock_2(hlock_2),
    .htrans(htrans), .hready(hready),
    .hgrant_0(hgrant_0), .hgrant_1(hgrant_1), .hgrant_2(hgrant_2),
    .hmaster(hmaster), .hmaster_data(hmaster_data), .hmastlock(hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    int gnt;
    int m;
    int md;
    int ml;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  // model state: st 0=park 1=own 2=lock
  int m_st, m_own, m_cnt, m_md, m_ml;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic mdl(input logic [2:0] req, input logic [2:0] lk,
                     input logic [1:0] tr, input logic rdy, input logic rst);
    int  oth, prev;
    bit  oth_v, own_lk;
    if (rst) begin
      m_st = 0; m_own = DEF; m_cnt = 0; m_md = DEF; m_ml = 0;
    end else if (rdy) begin
      oth = 0; oth_v = 0;
      for (int k = 1; k <= 2; k++)
        if (!oth_v && req[(m_own + k) % 3]) begin
          oth = (m_own + k) % 3; oth_v = 1;
        end
      prev   = m_own;
      own_lk = req[m_own] && lk[m_own];
      case (m_st)
        0: if (req != 3'b000) begin
             m_st = 1; m_cnt = 0;
             if (oth_v) m_own = oth;
           end
        1: if (own_lk) begin
             m_st = 2; m_ml = 1;
             if (tr[1] && m_cnt < MAXB) m_cnt++;
           end else if (!req[m_own] && oth_v) begin
             m_own = oth; m_cnt = 0;
           end else if (req == 3'b000) begin
             m_st = 0; m_own = DEF; m_cnt = 0;
           end else if (m_cnt == MAXB && oth_v) begin
             m_own = oth; m_cnt = 0;
           end else if (tr[1] && m_cnt < MAXB) begin
             m_cnt++;
           end
        default: if (!own_lk) begin
             m_ml = 0; m_cnt = 0; m_st = 1;
             if (!req[m_own] && oth_v) m_own = oth;
             else if (req == 3'b000) begin m_st = 0; m_own = DEF; end
           end
      endcase
      m_md = prev;
    end
  endtask

  // drive one cycle, queue the prediction, then compare after the edge
  task automatic drive(input logic [2:0] req, input logic [2:0] lk,
                       input logic [1:0] tr, input logic rdy, input logic rst);
    exp_t e, o;
    {hbusreq_2, hbusreq_1, hbusreq_0} = req;
    {hlock_2, hlock_1, hlock_0}       = lk;
    htrans = tr; hready = rdy; hreset = rst;
    mdl(req, lk, tr, rdy, rst);
    e.gnt = 1 << m_own; e.m = m_own; e.md = m_md; e.ml = m_ml;
    q.push_back(e);
    @(posedge hclk);
    #1;
    o = q.pop_front();
    chk("hgrant", int'({hgrant_2, hgrant_1, hgrant_0}), o.gnt);
    chk("hmaster", int'(hmaster), o.m);
    chk("hmaster_data", int'(hmaster_data), o.md);
    chk("hmastlock", int'(hmastlock), o.ml);
  endtask

  initial begin
    logic [2:0] rq, rl;
    logic [1:0] rt;
    {hbusreq_2, hbusreq_1, hbusreq_0} = 3'b000;
    {hlock_2, hlock_1, hlock_0}       = 3'b000;
    htrans = 2'b00; hready = 1'b1; hreset = 1'b1;
    m_st = 0; m_own = DEF; m_cnt = 0; m_md = DEF; m_ml = 0;

    // reset with all requests high
    repeat (2) drive(3'b111, 3'b000, 2'b10, 1'b1, 1'b1);
    chk("rst_hgrant_0", int'(hgrant_0), 1);
    chk("rst_hmaster", int'(hmaster), 0);
    chk("rst_hmaster_data", int'(hmaster_data), 0);
    chk("rst_hmastlock", int'(hmastlock), 0);

    // single request from master 2, then release -> park on 0
    drive(3'b100, 3'b000, 2'b10, 1'b1, 1'b0);
    chk("single_gnt2", int'(hgrant_2), 1);
    drive(3'b100, 3'b000, 2'b10, 1'b1, 1'b0);
    chk("single_mdata2", int'(hmaster_data), 2);
    repeat (2) drive(3'b000, 3'b000, 2'b00, 1'b1, 1'b0);
    chk("park_m0", int'(hmaster), 0);

    // round robin, all requesting, NONSEQ continuously
    drive(3'b001, 3'b000, 2'b10, 1'b1, 1'b0);
    repeat (16) drive(3'b111, 3'b000, 2'b10, 1'b1, 1'b0);

    // owner 1 with SEQ/BUSY alternating, master 2 waiting
    repeat (2) drive(3'b000, 3'b000, 2'b00, 1'b1, 1'b0);
    drive(3'b010, 3'b000, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++)
      drive(3'b110, 3'b000, (i % 2 == 0) ? 2'b11 : 2'b01, 1'b1, 1'b0);

    // locked sequence by master 1 with 0 and 2 contending, then unlock
    repeat (2) drive(3'b000, 3'b000, 2'b00, 1'b1, 1'b0);
    drive(3'b010, 3'b000, 2'b10, 1'b1, 1'b0);
    repeat (10) drive(3'b111, 3'b010, 2'b11, 1'b1, 1'b0);
    chk("lock_held", int'(hmastlock), 1);
    chk("lock_owner", int'(hmaster), 1);
    repeat (8) drive(3'b111, 3'b000, 2'b11, 1'b1, 1'b0);

    // stall across a pending handover (owner 0 drops, 1 requests)
    repeat (2) drive(3'b000, 3'b000, 2'b00, 1'b1, 1'b0);
    drive(3'b001, 3'b000, 2'b10, 1'b1, 1'b0);
    repeat (5) drive(3'b010, 3'b000, 2'b10, 1'b0, 1'b0);
    chk("stall_frozen", int'(hmaster), 0);
    repeat (2) drive(3'b010, 3'b000, 2'b10, 1'b1, 1'b0);
    chk("stall_release", int'(hmaster), 1);

    // reset in the middle of a lock
    drive(3'b010, 3'b010, 2'b10, 1'b1, 1'b0);
    drive(3'b010, 3'b010, 2'b10, 1'b1, 1'b1);
    chk("rst_mid_lock", int'(hmastlock), 0);
    drive(3'b010, 3'b000, 2'b10, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rq = 3'($urandom_range(7, 0));
      rl = 3'($urandom_range(7, 0));
      rt = 2'($urandom_range(3, 0));
      drive(rq, rl, rt, ($urandom_range(9, 0) < 8) ? 1'b1 : 1'b0,
            ($urandom_range(99, 0) < 2) ? 1'b1 : 1'b0);
    end

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
